// File: rtl/envelope_bank.sv
// envelope_bank: N_CH independent volume envelopes clocked by the 64 Hz frame clock.
//
// On a trigger, a channel loads its starting volume. It then steps that volume up or
// down by one every `period` frame ticks and saturates at 0 or at the maximum.
//
// Ports:
//   clk_64          64 Hz envelope frame clock (all state changes on its rising edge)
//   reset           synchronous active-high reset, overrides trigger
//   trigger         per-channel restart strobe
//   envelope_add    per-channel direction (1 = increase, 0 = decrease)
//   period          per-channel step period, channel i at [i*PERIOD_W +: PERIOD_W]
//   starting_volume per-channel initial volume, channel i at [i*VOL_W +: VOL_W]
//   volume          per-channel current volume (registered)
//   active          envelope still stepping
//   done            envelope reached its limit (sticky until trigger/reset)
//   dac_on          channel DAC enabled
//
// Optional feature macro: ENVELOPE_LIVE_UPDATE_EN. When it is defined, period and
// envelope_add are read live at every counter reload and step fire, and are not
// latched at trigger.
module envelope_bank #(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned VOL_W    = 4,
    parameter int unsigned PERIOD_W = 3
) (
    input  logic                     clk_64,
    input  logic                     reset,
    input  logic [N_CH-1:0]          trigger,
    input  logic [N_CH-1:0]          envelope_add,
    input  logic [N_CH*PERIOD_W-1:0] period,
    input  logic [N_CH*VOL_W-1:0]    starting_volume,
    output logic [N_CH*VOL_W-1:0]    volume,
    output logic [N_CH-1:0]          active,
    output logic [N_CH-1:0]          done,
    output logic [N_CH-1:0]          dac_on
);

    localparam logic [VOL_W-1:0]    VOL_MAX = '1;
    localparam logic [VOL_W-1:0]    VOL_ONE = 1;
    localparam logic [PERIOD_W-1:0] CNT_ONE = 1;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PERIOD_W-1:0] period_in;
        logic [VOL_W-1:0]    start_in;
        logic [VOL_W-1:0]    vol_q;
        logic [PERIOD_W-1:0] cnt_q;
        logic                active_q;
        logic                done_q;
        logic                dac_on_q;
        logic [PERIOD_W-1:0] reload_period;
        logic                step_dir;
        logic                at_limit;
        logic                hits_limit;

        assign period_in = period[i*PERIOD_W +: PERIOD_W];
        assign start_in  = starting_volume[i*VOL_W +: VOL_W];

`ifdef ENVELOPE_LIVE_UPDATE_EN
        assign reload_period = period_in;
        assign step_dir      = envelope_add[i];
`else
        logic [PERIOD_W-1:0] period_l_q;
        logic                dir_l_q;

        assign reload_period = period_l_q;
        assign step_dir      = dir_l_q;

        always_ff @(posedge clk_64) begin
            if (reset) begin
                period_l_q <= '0;
                dir_l_q    <= 1'b0;
            end else if (trigger[i]) begin
                period_l_q <= period_in;
                dir_l_q    <= envelope_add[i];
            end
        end
`endif

        // at_limit: a step would go past the limit. hits_limit: this step lands on it.
        assign at_limit   = step_dir ? (vol_q == VOL_MAX) : (vol_q == '0);
        assign hits_limit = step_dir ? (vol_q == VOL_MAX - VOL_ONE) : (vol_q == VOL_ONE);

        always_ff @(posedge clk_64) begin
            if (reset) begin
                vol_q    <= '0;
                cnt_q    <= '0;
                active_q <= 1'b0;
                done_q   <= 1'b0;
                dac_on_q <= 1'b0;
            end else if (trigger[i]) begin
                vol_q    <= start_in;
                cnt_q    <= period_in;
                active_q <= (period_in != '0);
                done_q   <= 1'b0;
                dac_on_q <= (start_in != '0) || envelope_add[i];
            end else if (active_q) begin
                if (cnt_q > CNT_ONE) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end else begin
                    cnt_q <= reload_period;
                    if (reload_period == '0) begin
                        // A live period of 0 freezes the channel. Volume and done are held.
                        active_q <= 1'b0;
                    end else if (at_limit) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        vol_q <= step_dir ? vol_q + VOL_ONE : vol_q - VOL_ONE;
                        if (hits_limit) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
            end
        end

        assign volume[i*VOL_W +: VOL_W] = vol_q;
        assign active[i]                = active_q;
        assign done[i]                  = done_q;
        assign dac_on[i]                = dac_on_q;
    end

endmodule

// File: tb/tb_envelope_bank.sv
// Self-checking bench for envelope_bank (default parameters).
// It applies directed table vectors and hand-written corner-case sequences. It then runs
// random stimulus against a closed-form reference model. The model derives each output
// from the number of edges seen since the last trigger.
module tb_envelope_bank;

    localparam int N_CH = 3;
    localparam int VOL_W = 4;
    localparam int PERIOD_W = 3;
    localparam int VMAX = 15;

    logic                     clk_64 = 1'b0;
    logic                     reset;
    logic [N_CH-1:0]          trigger;
    logic [N_CH-1:0]          envelope_add;
    logic [N_CH*PERIOD_W-1:0] period;
    logic [N_CH*VOL_W-1:0]    starting_volume;
    logic [N_CH*VOL_W-1:0]    volume;
    logic [N_CH-1:0]          active;
    logic [N_CH-1:0]          done;
    logic [N_CH-1:0]          dac_on;

    int n_chk = 0;
    int n_fail = 0;

    envelope_bank #(
        .N_CH    (N_CH),
        .VOL_W   (VOL_W),
        .PERIOD_W(PERIOD_W)
    ) dut (
        .clk_64         (clk_64),
        .reset          (reset),
        .trigger        (trigger),
        .envelope_add   (envelope_add),
        .period         (period),
        .starting_volume(starting_volume),
        .volume         (volume),
        .active         (active),
        .done           (done),
        .dac_on         (dac_on)
    );

    always #5 clk_64 = ~clk_64;

    typedef struct {
        int ch;
        int start;
        int per;
        int add;
        int edges;
        int e_vol;
        int e_act;
        int e_done;
        int e_dac;
    } vec_t;

    vec_t vecs[$];

    // Reference model state.
    int m_valid[N_CH];
    int m_k[N_CH];
    int m_s[N_CH];
    int m_p[N_CH];
    int m_a[N_CH];
    int m_dac[N_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] vol_of(input int c);
        return 32'(volume[c*VOL_W +: VOL_W]);
    endfunction

    task automatic set_ch(input int c, input int s, input int p, input int a);
        starting_volume[c*VOL_W +: VOL_W] = s[VOL_W-1:0];
        period[c*PERIOD_W +: PERIOD_W]    = p[PERIOD_W-1:0];
        envelope_add[c]                   = a[0];
    endtask

    task automatic tick();
        @(posedge clk_64);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        trigger = '0;
        tick();
        reset = 1'b0;
    endtask

    // Closed-form expectation: steps = edges / period, clamped at the limit. A step that
    // fires while already at the limit also ends the envelope.
    task automatic model_exp(input int c, output int v, output int a, output int d,
                             output int dc);
        int steps;
        int need;
        if (m_valid[c] == 0) begin
            v = 0; a = 0; d = 0; dc = 0;
        end else begin
            dc = m_dac[c];
            if (m_p[c] == 0) begin
                v = m_s[c]; a = 0; d = 0;
            end else begin
                steps = m_k[c] / m_p[c];
                if (m_a[c] != 0) begin
                    need = (VMAX - m_s[c] > 0) ? VMAX - m_s[c] : 1;
                    v = (m_s[c] + steps > VMAX) ? VMAX : m_s[c] + steps;
                end else begin
                    need = (m_s[c] > 0) ? m_s[c] : 1;
                    v = (steps > m_s[c]) ? 0 : m_s[c] - steps;
                end
                d = (steps >= need) ? 1 : 0;
                a = 1 - d;
            end
        end
    endtask

    // Advance the model by one edge using the inputs presented at that edge.
    task automatic model_edge();
        for (int c = 0; c < N_CH; c++) begin
            if (reset) begin
                m_valid[c] = 0; m_k[c] = 0; m_dac[c] = 0;
            end else if (trigger[c]) begin
                m_valid[c] = 1;
                m_k[c]     = 0;
                m_s[c]     = int'(starting_volume[c*VOL_W +: VOL_W]);
                m_p[c]     = int'(period[c*PERIOD_W +: PERIOD_W]);
                m_a[c]     = int'(envelope_add[c]);
                m_dac[c]   = (m_s[c] != 0 || m_a[c] != 0) ? 1 : 0;
            end else if (m_valid[c] != 0 && m_k[c] < 100000) begin
                m_k[c]++;
            end
        end
    endtask

    initial begin
        int v, a, d, dc;

        reset = 1'b1; trigger = '0; envelope_add = '0; period = '0; starting_volume = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_volume", 32'(volume), 0);
        check("reset_active", 32'(active), 0);
        check("reset_done", 32'(done), 0);
        check("reset_dac_on", 32'(dac_on), 0);

        //                 ch st per add edges vol act done dac
        vecs.push_back('{0, 15, 1, 0, 0, 15, 1, 0, 1});
        vecs.push_back('{0, 15, 1, 0, 5, 10, 1, 0, 1});
        vecs.push_back('{0, 15, 1, 0, 14, 1, 1, 0, 1});
        vecs.push_back('{0, 15, 1, 0, 15, 0, 0, 1, 1});
        vecs.push_back('{0, 15, 1, 0, 25, 0, 0, 1, 1});
        vecs.push_back('{1, 8, 3, 1, 0, 8, 1, 0, 1});
        vecs.push_back('{1, 8, 3, 1, 2, 8, 1, 0, 1});
        vecs.push_back('{1, 8, 3, 1, 3, 9, 1, 0, 1});
        vecs.push_back('{1, 8, 3, 1, 20, 14, 1, 0, 1});
        vecs.push_back('{1, 8, 3, 1, 21, 15, 0, 1, 1});
        vecs.push_back('{2, 0, 1, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{2, 0, 1, 0, 1, 0, 0, 1, 0});
        vecs.push_back('{2, 0, 2, 1, 4, 2, 1, 0, 1});
        vecs.push_back('{2, 9, 0, 0, 50, 9, 0, 0, 1});
        vecs.push_back('{0, 15, 7, 1, 7, 15, 0, 1, 1});
        vecs.push_back('{1, 0, 5, 1, 0, 0, 1, 0, 1});

        foreach (vecs[n]) begin
            do_reset();
            set_ch(vecs[n].ch, vecs[n].start, vecs[n].per, vecs[n].add);
            trigger[vecs[n].ch] = 1'b1;
            tick();
            trigger = '0;
            for (int e = 0; e < vecs[n].edges; e++) tick();
            check($sformatf("vec%0d_volume", n), vol_of(vecs[n].ch), 32'(vecs[n].e_vol));
            check($sformatf("vec%0d_active", n), 32'(active[vecs[n].ch]), 32'(vecs[n].e_act));
            check($sformatf("vec%0d_done", n), 32'(done[vecs[n].ch]), 32'(vecs[n].e_done));
            check($sformatf("vec%0d_dac_on", n), 32'(dac_on[vecs[n].ch]), 32'(vecs[n].e_dac));
            for (int c = 0; c < N_CH; c++) begin
                if (c != vecs[n].ch) begin
                    check($sformatf("vec%0d_other%0d", n, c), vol_of(c) | 32'(dac_on[c]), 0);
                end
            end
        end

        // Retrigger ch0 at volume 7, then reset coinciding with a trigger on ch1.
        do_reset();
        set_ch(0, 15, 1, 0);
        trigger = 3'b001;
        tick();
        trigger = '0;
        for (int e = 0; e < 8; e++) tick();
        check("retrig_before", vol_of(0), 7);
        set_ch(0, 12, 2, 0);
        trigger = 3'b001;
        tick();
        trigger = '0;
        check("retrig_load", vol_of(0), 12);
        check("retrig_active", 32'(active[0]), 1);
        tick();
        check("retrig_hold", vol_of(0), 12);
        tick();
        check("retrig_step", vol_of(0), 11);
        set_ch(1, 5, 2, 1);
        reset = 1'b1;
        trigger = 3'b010;
        tick();
        reset = 1'b0;
        trigger = '0;
        check("reset_wins_vol", 32'(volume), 0);
        check("reset_wins_flags", 32'({active, done, dac_on}), 0);

        // Period change mid-envelope, period 1 -> 4.
        do_reset();
        set_ch(0, 15, 1, 0);
        trigger = 3'b001;
        tick();
        trigger = '0;
        tick();
        tick();
        check("pchg_pre", vol_of(0), 13);
        set_ch(0, 15, 4, 0);
        tick();
        check("pchg_next", vol_of(0), 12);
        for (int e = 0; e < 4; e++) tick();
`ifdef ENVELOPE_LIVE_UPDATE_EN
        check("pchg_spacing", vol_of(0), 11);
`else
        check("pchg_spacing", vol_of(0), 8);
`endif

        // Random phase against the reference model.
        do_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_valid[c] = 0; m_k[c] = 0; m_dac[c] = 0; m_s[c] = 0; m_p[c] = 0; m_a[c] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int c = 0; c < N_CH; c++) begin
                trigger[c] = ($urandom_range(0, 9) == 0);
`ifdef ENVELOPE_LIVE_UPDATE_EN
                if (trigger[c])
`endif
                set_ch(c, int'($urandom_range(0, VMAX)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 1)));
            end
            tick();
            model_edge();
            for (int c = 0; c < N_CH; c++) begin
                model_exp(c, v, a, d, dc);
                check($sformatf("rnd_vol%0d", c), vol_of(c), 32'(v));
                check($sformatf("rnd_act%0d", c), 32'(active[c]), 32'(a));
                check($sformatf("rnd_done%0d", c), 32'(done[c]), 32'(d));
                check($sformatf("rnd_dac%0d", c), 32'(dac_on[c]), 32'(dc));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
